// File: rtl/codec2_pkg.sv
// Shared constants, FSM encoding and sign-magnitude field layout
// for the speech_to_uq_lsps front end (hanning window, autocorrelation).
package codec2_pkg;

    localparam int N    = 32;
    localparam int Q    = 16;
    localparam int NSAM = 320;

    localparam int SIGN_BIT = N - 1;
    localparam int MAG_MSB  = N - 2;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_INIT   = 4'd1;
    localparam logic [3:0] ST_ACCEPT = 4'd2;
    localparam logic [3:0] ST_MULT   = 4'd3;
    localparam logic [3:0] ST_WRITE  = 4'd4;
    localparam logic [3:0] ST_INCR   = 4'd5;
    localparam logic [3:0] ST_DONE   = 4'd6;

    typedef enum logic [3:0] {
        IDLE   = ST_IDLE,
        INIT   = ST_INIT,
        ACCEPT = ST_ACCEPT,
        MULT   = ST_MULT,
        WRITE  = ST_WRITE,
        INCR   = ST_INCR,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/sm_qmult_sat.sv
// Combinational sign-magnitude Q-format multiply.
// WINDOW_SATURATE_EN: clamp magnitude on overflow instead of truncating.
module sm_qmult_sat #(
    parameter int N = codec2_pkg::N,
    parameter int Q = codec2_pkg::Q
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    localparam int PW = 2 * (N - 1);

    logic [PW-1:0] full;
    logic [N-2:0]  mag;
    logic          sgn;
    logic          unused_bits;

    // full-width magnitude product
    assign full = PW'(a[N-2:0]) * PW'(b[N-2:0]);

`ifdef WINDOW_SATURATE_EN
    logic ovf;

    // any bit above the kept window forces full-scale magnitude
    assign ovf         = |full[PW-1:N-1+Q];
    assign mag         = ovf ? '1 : full[N-2+Q:Q];
    assign unused_bits = ^full[Q-1:0];
`else
    // upper bits dropped, same as qmult
    assign mag         = full[N-2+Q:Q];
    assign unused_bits = ^{full[PW-1:N-1+Q], full[Q-1:0]};
`endif

    // a zero magnitude always leaves as +0
    assign sgn = (a[N-1] ^ b[N-1]) & (|mag);
    assign y   = {sgn, mag};

endmodule

// File: rtl/hanning_window_sn.sv
// Windows one speech frame and writes it into the Sn RAM.
// Build option WINDOW_SATURATE_EN selects saturating multiply.
module hanning_window_sn #(
    parameter int N    = codec2_pkg::N,
    parameter int Q    = codec2_pkg::Q,
    parameter int NSAM = codec2_pkg::NSAM
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         startwn,
    input  logic         in_valid,
    input  logic [N-1:0] in_sample,
    output logic         in_ready,
    output logic [8:0]   win_addr,
    input  logic [N-1:0] win_data,
    output logic [8:0]   sn_addr,
    output logic [N-1:0] sn_wdata,
    output logic         sn_wren,
    output logic         donewn
);

    import codec2_pkg::*;

    localparam logic [8:0] LAST = 9'(NSAM - 1);

    state_t       state;
    logic [8:0]   i;
    logic [N-1:0] x;
    logic [N-1:0] p;
    logic [N-1:0] prod;

    sm_qmult_sat #(
        .N(N),
        .Q(Q)
    ) u_mult (
        .a(x),
        .b(win_data),
        .y(prod)
    );

    // ready is a pure state decode so reset clears it at once
    assign in_ready = (state == ACCEPT);

    // frame sequencer: accept, multiply, write, advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            i        <= '0;
            x        <= '0;
            p        <= '0;
            win_addr <= '0;
            sn_addr  <= '0;
            sn_wdata <= '0;
            sn_wren  <= 1'b0;
            donewn   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startwn) state <= INIT;
                end
                INIT: begin
                    i        <= '0;
                    win_addr <= '0;
                    donewn   <= 1'b0;
                    state    <= ACCEPT;
                end
                ACCEPT: begin
                    if (in_valid) begin
                        x     <= in_sample;
                        state <= MULT;
                    end
                end
                MULT: begin
                    p     <= prod;
                    state <= WRITE;
                end
                WRITE: begin
                    sn_addr  <= i;
                    sn_wdata <= p;
                    sn_wren  <= 1'b1;
                    state    <= INCR;
                end
                INCR: begin
                    sn_wren <= 1'b0;
                    if (i == LAST) begin
                        state <= DONE;
                    end else begin
                        i        <= i + 9'd1;
                        win_addr <= i + 9'd1;
                        state    <= ACCEPT;
                    end
                end
                DONE: begin
                    donewn <= 1'b1;
                    if (!startwn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hanning_window_sn.md
# hanning_window_sn

Applies the analysis window to one frame of input speech and writes the windowed samples, one per address, into the Sn RAM. The autocorrelation stage then reads that RAM. The block sits ahead of autocorrelation inside speech_to_uq_lsps and uses the same start/done level handshake. Samples arrive over a valid/ready stream. Window coefficients come from an external synchronous ROM.

## Interface
Parameters:
- N, 32, word width; sign-magnitude fixed point, 1 sign bit, 15 integer bits, 16 fraction bits
- Q, 16, fraction bits
- NSAM, 320, samples per frame

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- startwn  input  1  start request, sampled in IDLE only
- in_valid  input  1  input sample valid
- in_sample  input  N  input speech sample
- in_ready  output  1  block accepts sample this cycle
- win_addr  output  9  window ROM address
- win_data  input  N  window coefficient, valid 1 cycle after win_addr changes
- sn_addr  output  9  Sn RAM write address
- sn_wdata  output  N  windowed sample
- sn_wren  output  1  Sn RAM write enable
- donewn  output  1  frame written, level

## Operation
- States: IDLE, INIT, ACCEPT, MULT, WRITE, INCR, DONE.
- IDLE: if startwn is high, go to INIT; otherwise stay.
- INIT:
  - i<=0, win_addr<=0, donewn<=0
  - go to ACCEPT
- ACCEPT:
  - in_ready=1, decoded combinationally from state
  - on in_valid: latch in_sample into x, go to MULT
  - otherwise stay
- MULT:
  - sign: p.sign = x.sign XOR win_data.sign
  - magnitude: p.mag = (|x|·|w|)>>Q, bits [N-2:0]; the full product is 2(N-1) bits
  - go to WRITE
- WRITE:
  - sn_addr<=i, sn_wdata<=p, sn_wren<=1
  - go to INCR
- INCR:
  - sn_wren<=0
  - if i==NSAM-1, go to DONE
  - otherwise i<=i+1, win_addr<=i+1, go to ACCEPT
- DONE:
  - donewn<=1
  - when startwn is low, go to IDLE; donewn stays 1 until the next INIT
- Behaviour when startwn is asserted outside IDLE: ignored.
- Behaviour when in_valid is asserted outside ACCEPT: no sample is consumed.
- Negative-zero product (sign set, magnitude 0): written as 0x00000000.
- Reset mid-frame:
  - state returns to IDLE immediately
  - any partial frame is abandoned; addresses already written are not cleared
- Reset values:
  - in_ready=0, sn_wren=0, donewn=0
  - sn_addr=0, sn_wdata=0, win_addr=0
  - i=0, x=0, p=0

## Timing
- Minimum cost is 4 cycles per sample: ACCEPT, MULT, WRITE, INCR.
- Minimum frame latency is 1+4·NSAM+1 cycles from INIT to donewn=1, i.e. 1282 cycles at NSAM=320.
- win_addr is stable for at least 1 cycle before MULT. The ROM read latency is therefore covered by the ACCEPT cycle.
- sn_wren is high for exactly 1 cycle per sample. There are NSAM writes per frame at addresses 0..NSAM-1 in ascending order.
- Source stall: each cycle that in_valid stays low in ACCEPT adds 1 cycle.
- donewn rises on the cycle after DONE is entered.

## Configuration
- WINDOW_SATURATE_EN defined:
  - if any product magnitude bit above [N-2+Q:Q] is set, p.mag saturates to all ones (0x7FFFFFFF magnitude)
  - the sign is kept
- WINDOW_SATURATE_EN undefined: the upper bits are discarded (truncation), matching qmult.

## Structure
- Shared package codec2_pkg holds:
  - N, Q, NSAM
  - the state encoding, 4-bit localparams
  - the sign-magnitude field positions
- One sub-module, sm_qmult_sat:
  - combinational sign-magnitude multiply with the saturation option
  - instantiated once
  - the FSM and counters live in the top module

## Test plan
- Window all 0x00010000 (1.0), samples 0..319 as 0x00010000·k, in_valid held high → RAM[k]=0x00010000·k, donewn after 1282 cycles.
- x=0x00020000 (2.0), w=0x00008000 (0.5) → 0x00010000; x=0x80020000 (-2.0), same w → 0x80010000.
- x=0x7FFF0000, w=0x00020000:
  - with WINDOW_SATURATE_EN → 0x7FFFFFFF
  - without → 0x7FFE0000
- in_valid deasserted for 5 cycles mid-frame → in_ready stays high, no sn_wren pulse, addresses contiguous, latency +5.
- rst low at sample 100 → all outputs at reset values the same cycle, no further writes; a new startwn rewrites from address 0.
- startwn pulsed during ACCEPT → ignored; startwn held high through DONE → block stays in DONE until startwn falls.
